// File: rtl/free_list_ctrl_if.sv
// Bundle between the rename/commit stages and free_list_ctrl: decode request,
// commit returns, packed return ports to free_list, and flush/status signals.
interface free_list_ctrl_if #(
  parameter int TAG_W = 6
);
  logic [3:0]       i_dec_valid;
  logic [3:0]       i_dec_has_rd;
  logic             o_dec_ready;
  logic [2:0]       o_req_count;
  logic [3:0]       i_com_free;
  logic [TAG_W-1:0] i_com_p0;
  logic [TAG_W-1:0] i_com_p1;
  logic [TAG_W-1:0] i_com_p2;
  logic [TAG_W-1:0] i_com_p3;
  logic [2:0]       o_ret_count;
  logic [TAG_W-1:0] o_ret_p0;
  logic [TAG_W-1:0] o_ret_p1;
  logic [TAG_W-1:0] o_ret_p2;
  logic [TAG_W-1:0] o_ret_p3;
  logic             i_flush;
  logic             i_recover_done;
  logic [6:0]       o_free_count;
  logic             o_recovering;
  logic [15:0]      o_stall_cycles;

  modport slave (
    input  i_dec_valid, i_dec_has_rd, i_com_free,
    input  i_com_p0, i_com_p1, i_com_p2, i_com_p3,
    input  i_flush, i_recover_done,
    output o_dec_ready, o_req_count, o_ret_count,
    output o_ret_p0, o_ret_p1, o_ret_p2, o_ret_p3,
    output o_free_count, o_recovering, o_stall_cycles
  );

  modport master (
    output i_dec_valid, i_dec_has_rd, i_com_free,
    output i_com_p0, i_com_p1, i_com_p2, i_com_p3,
    output i_flush, i_recover_done,
    input  o_dec_ready, o_req_count, o_ret_count,
    input  o_ret_p0, o_ret_p1, o_ret_p2, o_ret_p3,
    input  o_free_count, o_recovering, o_stall_cycles
  );
endinterface

// File: rtl/free_list_ctrl.sv
// Allocation/return controller for free_list: grants decode groups against a
// mirrored free count, packs commit returns, and blocks allocation during flush.
// Optional properties are compiled in with FREE_LIST_CTRL_FORMAL_EN.
module free_list_ctrl #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = 6,
  parameter int WIDTH     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  free_list_ctrl_if.slave       bus
);
  localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [6:0]       r_free_count;
  logic [2:0]       r_ret_cnt;
  logic [TAG_W-1:0] r_ret_p [WIDTH];
  logic [15:0]      r_stall;

  logic [2:0]       w_need;
  logic             w_dec_ready;
  logic [2:0]       w_req;
  logic [7:0]       w_free_next;
  logic [2:0]       w_ret_cnt;
  logic [TAG_W-1:0] w_com_p [WIDTH];
  logic [TAG_W-1:0] w_ret_p [WIDTH];

  assign w_com_p[0] = bus.i_com_p0;
  assign w_com_p[1] = bus.i_com_p1;
  assign w_com_p[2] = bus.i_com_p2;
  assign w_com_p[3] = bus.i_com_p3;

  assign w_need      = 3'($countones(bus.i_dec_valid & bus.i_dec_has_rd));
  // Grant checks only the registered count; same-cycle returns are not bypassed.
  assign w_dec_ready = i_rst_n && (r_state == ST_RUN) && !bus.i_flush &&
                       ({4'b0, w_need} <= r_free_count);
  assign w_req       = w_dec_ready ? w_need : 3'd0;
  assign w_free_next = {1'b0, r_free_count} - {5'b0, w_req} + {5'b0, r_ret_cnt};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (bus.i_flush) w_state_next = ST_FLUSH;
      ST_FLUSH: if (bus.i_recover_done && !bus.i_flush) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // Pack released tags lowest slot first; unused lanes stay zero.
  always_comb begin
    logic [2:0] idx;
    idx       = 3'd0;
    w_ret_cnt = 3'd0;
    for (int s = 0; s < WIDTH; s++) w_ret_p[s] = '0;
    for (int s = 0; s < WIDTH; s++) begin
      if (bus.i_com_free[s]) begin
        w_ret_p[idx[1:0]] = w_com_p[s];
        idx               = idx + 3'd1;
      end
    end
    w_ret_cnt = idx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_RUN;
      r_free_count <= 7'(FREE_INIT);
      r_ret_cnt    <= 3'd0;
      r_stall      <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_free_count <= w_free_next[6:0];
      r_ret_cnt    <= w_ret_cnt;
      if (|bus.i_dec_valid && !w_dec_ready && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ret
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_ret_p[gi] <= '0;
      else          r_ret_p[gi] <= w_ret_p[gi];
    end
  end

  assign bus.o_dec_ready    = w_dec_ready;
  assign bus.o_req_count    = w_req;
  assign bus.o_ret_count    = r_ret_cnt;
  assign bus.o_ret_p0       = r_ret_p[0];
  assign bus.o_ret_p1       = r_ret_p[1];
  assign bus.o_ret_p2       = r_ret_p[2];
  assign bus.o_ret_p3       = r_ret_p[3];
  assign bus.o_free_count   = r_free_count;
  assign bus.o_recovering   = (r_state == ST_FLUSH);
  assign bus.o_stall_cycles = r_stall;

`ifdef FREE_LIST_CTRL_FORMAL_EN
  logic f_past_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) f_past_valid <= 1'b1;
  end

  always_comb begin
    if (!f_past_valid) assume (!i_rst_n);
    for (int s = 0; s < WIDTH; s++) begin
      if (bus.i_com_free[s]) assume (int'(w_com_p[s]) >= ARCH_REGS);
    end
    if (f_past_valid && i_rst_n) begin
      assert (int'(r_free_count) <= FREE_INIT);
      assert ({4'b0, w_req} <= r_free_count);
      if (r_state == ST_FLUSH) assert (w_req == 3'd0);
      for (int n = 0; n < WIDTH; n++) begin
        if (n >= int'(r_ret_cnt)) assert (r_ret_p[n] == '0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (f_past_valid && i_rst_n)
      cover (r_state == ST_FLUSH && w_state_next == ST_RUN &&
             int'(r_free_count) == FREE_INIT);
  end
`endif
endmodule
